// File: rtl/adc16dv160_input_read_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adc16dv160_input_common : shared register map and read-FSM types     |
// | Revision: 1.1                                                        |
// +----------------------------------------------------------------------+
package adc16dv160_input_common;

   localparam logic [7:0] AXI_ADDR_CR    = 8'h00;
   localparam logic [7:0] AXI_ADDR_DSIZE = 8'h04;
   localparam logic [7:0] AXI_ADDR_SR    = 8'h08;
   localparam logic [7:0] AXI_ADDR_CNT   = 8'h0C;
   localparam logic [7:0] AXI_ADDR_ID    = 8'h10;

   localparam int SR_BUSY_BIT = 0;
   localparam int SR_DONE_BIT = 1;
   localparam int SR_OVF_BIT  = 2;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

   typedef enum logic [1:0] {
      RD_IDLE = 2'd0,
      RD_ADDR = 2'd1,
      RD_DATA = 2'd2
   } rd_state_t;

   function automatic logic [31:0] sr_word(input logic busy, input logic done, input logic ovf);
      logic [31:0] w;
      w              = '0;
      w[SR_BUSY_BIT] = busy;
      w[SR_DONE_BIT] = done;
      w[SR_OVF_BIT]  = ovf;
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/adc16dv160_input_read_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adc16dv160_input_read_if : AXI4-Lite AR/R channel bundle             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface adc16dv160_input_read_if;
   logic [31:0] ARADDR;
   logic        ARVALID;
   logic        ARREADY;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RVALID;
   logic        RREADY;

   modport master (
      output ARADDR, ARVALID, RREADY,
      input  ARREADY, RDATA, RRESP, RVALID
   );

   modport slave (
      input  ARADDR, ARVALID, RREADY,
      output ARREADY, RDATA, RRESP, RVALID
   );
endinterface
`default_nettype wire

// File: rtl/adc16dv160_input_sticky.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adc16dv160_input_sticky : event flag, set has priority over clear    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module adc16dv160_input_sticky
   import adc16dv160_input_common::*;
(
   input  wire logic ACLK,
   input  wire logic ARESETN,
   input  wire logic i_set,
   input  wire logic i_clr,
   output logic      o_flag
);

   logic r_flag;

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_flag <= 1'b0;
      end else if (i_set) begin
         r_flag <= 1'b1;
      end else if (i_clr) begin
         r_flag <= 1'b0;
      end
   end

   assign o_flag = r_flag;

endmodule
`default_nettype wire

// File: rtl/adc16dv160_input_read.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adc16dv160_input_read : AXI4-Lite read responder for the input core  |
// | Option macro ADC16DV160_INPUT_ID_EN maps ID_VALUE at 0x10. Rev 1.1   |
// +----------------------------------------------------------------------+
module adc16dv160_input_read
   import adc16dv160_input_common::*;
#(
   parameter logic [31:0] ID_VALUE = 32'h1616_0100
)(
   input  wire logic        ACLK,
   input  wire logic        ARESETN,
   adc16dv160_input_read_if.slave axi,
   input  wire logic [31:0] dsize,
   input  wire logic        cr_test,
   input  wire logic        cr_rt,
   input  wire logic        busy,
   input  wire logic        done_pulse,
   input  wire logic        ovf_pulse,
   input  wire logic [31:0] sample_cnt
);

   rd_state_t   r_state;
   logic        r_arready;
   logic        r_rvalid;
   logic [31:0] r_rdata;
   logic [7:0]  r_addr;

   logic [31:0] w_rd_word;
   logic        w_sr_clr;
   logic        w_done_sticky;
   logic        w_ovf_sticky;
   logic        w_unused_addr;

   assign w_unused_addr = ^axi.ARADDR[31:8];

`ifndef ADC16DV160_INPUT_ID_EN
   logic w_unused_id;
   assign w_unused_id = ^ID_VALUE;
`endif

   // Stickies clear only when an SR read is actually consumed by the master.
   assign w_sr_clr = (r_state == RD_DATA) && axi.RREADY && (r_addr == AXI_ADDR_SR);

   adc16dv160_input_sticky u_done_sticky (
      .ACLK    (ACLK),
      .ARESETN (ARESETN),
      .i_set   (done_pulse),
      .i_clr   (w_sr_clr),
      .o_flag  (w_done_sticky)
   );

   adc16dv160_input_sticky u_ovf_sticky (
      .ACLK    (ACLK),
      .ARESETN (ARESETN),
      .i_set   (ovf_pulse),
      .i_clr   (w_sr_clr),
      .o_flag  (w_ovf_sticky)
   );

   always_comb begin
      w_rd_word = '0;
      case (axi.ARADDR[7:0])
         AXI_ADDR_CR:    w_rd_word = {29'b0, cr_rt, cr_test, 1'b0};
         AXI_ADDR_DSIZE: w_rd_word = dsize;
         AXI_ADDR_SR:    w_rd_word = sr_word(busy, w_done_sticky, w_ovf_sticky);
         AXI_ADDR_CNT:   w_rd_word = sample_cnt;
`ifdef ADC16DV160_INPUT_ID_EN
         AXI_ADDR_ID:    w_rd_word = ID_VALUE;
`endif
         default:        w_rd_word = '0;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_state   <= RD_IDLE;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
         r_addr    <= '0;
      end else begin
         case (r_state)
            RD_IDLE: begin
               if (axi.ARVALID) begin
                  r_state   <= RD_ADDR;
                  r_arready <= 1'b1;
               end
            end
            RD_ADDR: begin
               r_arready <= 1'b0;
               r_addr    <= axi.ARADDR[7:0];
               r_rdata   <= w_rd_word;
               r_rvalid  <= 1'b1;
               r_state   <= RD_DATA;
            end
            RD_DATA: begin
               if (axi.RREADY) begin
                  r_rvalid <= 1'b0;
                  r_state  <= RD_IDLE;
               end
            end
            default: begin
               r_state   <= RD_IDLE;
               r_arready <= 1'b0;
               r_rvalid  <= 1'b0;
            end
         endcase
      end
   end

   assign axi.ARREADY = r_arready;
   assign axi.RVALID  = r_rvalid;
   assign axi.RDATA   = r_rdata;
   assign axi.RRESP   = AXI_RESP_OKAY;

endmodule
`default_nettype wire

// File: tb/tb_adc16dv160_input_read.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_adc16dv160_input_read : randomized bench with register-map model  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_adc16dv160_input_read;

   logic        ACLK = 1'b0;
   logic        ARESETN = 1'b0;
   logic [31:0] dsize = '0;
   logic        cr_test = 1'b0;
   logic        cr_rt = 1'b0;
   logic        busy = 1'b0;
   logic        done_pulse = 1'b0;
   logic        ovf_pulse = 1'b0;
   logic [31:0] sample_cnt = '0;

   int n_checks = 0;
   int n_errors = 0;

   // Model of the sticky event flags
   logic m_done = 1'b0;
   logic m_ovf  = 1'b0;

   always #5 ACLK = ~ACLK;

   adc16dv160_input_read_if axi ();

   adc16dv160_input_read dut (
      .ACLK       (ACLK),
      .ARESETN    (ARESETN),
      .axi        (axi),
      .dsize      (dsize),
      .cr_test    (cr_test),
      .cr_rt      (cr_rt),
      .busy       (busy),
      .done_pulse (done_pulse),
      .ovf_pulse  (ovf_pulse),
      .sample_cnt (sample_cnt)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_reg(input logic [7:0] a);
      case (a)
         8'h00:   return 32'(cr_rt) * 4 + 32'(cr_test) * 2;
         8'h04:   return dsize;
         8'h08:   return 32'(m_ovf) * 4 + 32'(m_done) * 2 + 32'(busy);
         8'h0C:   return sample_cnt;
`ifdef ADC16DV160_INPUT_ID_EN
         8'h10:   return 32'h1616_0100;
`endif
         default: return 32'h0;
      endcase
   endfunction

   task automatic randomize_inputs();
      dsize      = $urandom();
      cr_test    = 1'($urandom_range(0, 1));
      cr_rt      = 1'($urandom_range(0, 1));
      busy       = 1'($urandom_range(0, 1));
      sample_cnt = $urandom();
   endtask

   task automatic pulse(input logic pd, input logic po);
      @(negedge ACLK);
      done_pulse = pd;
      ovf_pulse  = po;
      @(negedge ACLK);
      done_pulse = 1'b0;
      ovf_pulse  = 1'b0;
      if (pd) m_done = 1'b1;
      if (po) m_ovf  = 1'b1;
   endtask

   // One read; pd/po fire in the handshake cycle, vary churns inputs while stalled.
   task automatic do_read(input logic [7:0] a, input int stall, input logic pd,
                          input logic po, input logic vary);
      logic [31:0] exp;
      logic [31:0] r;
      @(negedge ACLK);
      r           = $urandom();
      axi.ARADDR  = {r[31:8], a};
      axi.ARVALID = 1'b1;
      axi.RREADY  = 1'b0;
      @(posedge ACLK); #1;
      check_eq("arready_n1", 32'(axi.ARREADY), 32'd1);
      check_eq("rvalid_n1", 32'(axi.RVALID), 32'd0);
      @(negedge ACLK);
      exp = model_reg(a);
      @(posedge ACLK); #1;
      axi.ARVALID = 1'b0;
      axi.ARADDR  = $urandom();
      check_eq("arready_n2", 32'(axi.ARREADY), 32'd0);
      check_eq("rvalid_n2", 32'(axi.RVALID), 32'd1);
      check_eq("rdata", axi.RDATA, exp);
      check_eq("rresp", 32'(axi.RRESP), 32'd0);
      for (int i = 0; i < stall; i++) begin
         @(negedge ACLK);
         if (vary) begin
            sample_cnt  = sample_cnt + 32'($urandom_range(1, 9));
            dsize       = $urandom();
            busy        = ~busy;
            axi.ARVALID = 1'($urandom_range(0, 1));
         end
         @(posedge ACLK); #1;
         check_eq("rvalid_stall", 32'(axi.RVALID), 32'd1);
         check_eq("rdata_stall", axi.RDATA, exp);
      end
      @(negedge ACLK);
      axi.ARVALID = 1'b0;
      axi.RREADY  = 1'b1;
      done_pulse  = pd;
      ovf_pulse   = po;
      @(posedge ACLK); #1;
      axi.RREADY = 1'b0;
      done_pulse = 1'b0;
      ovf_pulse  = 1'b0;
      if (a == 8'h08) begin
         m_done = 1'b0;
         m_ovf  = 1'b0;
      end
      if (pd) m_done = 1'b1;
      if (po) m_ovf  = 1'b1;
      check_eq("rvalid_end", 32'(axi.RVALID), 32'd0);
      check_eq("arready_end", 32'(axi.ARREADY), 32'd0);
   endtask

   initial begin
      logic [7:0] addr_list [6];
      logic [7:0] a;
      logic [31:0] r;
      addr_list = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h40};
      axi.ARADDR  = '0;
      axi.ARVALID = 1'b0;
      axi.RREADY  = 1'b0;

      #12;
      check_eq("rst_arready", 32'(axi.ARREADY), 32'd0);
      check_eq("rst_rvalid", 32'(axi.RVALID), 32'd0);
      check_eq("rst_rdata", axi.RDATA, 32'd0);
      check_eq("rst_rresp", 32'(axi.RRESP), 32'd0);
      @(negedge ACLK);
      ARESETN = 1'b1;

      dsize = 32'h0000_1000;
      do_read(8'h04, 0, 1'b0, 1'b0, 1'b0);
      cr_test = 1'b1;
      cr_rt   = 1'b1;
      do_read(8'h00, 0, 1'b0, 1'b0, 1'b0);
      busy = 1'b0;
      pulse(1'b1, 1'b0);
      do_read(8'h08, 0, 1'b0, 1'b0, 1'b0);
      do_read(8'h08, 0, 1'b0, 1'b0, 1'b0);
      do_read(8'h08, 0, 1'b0, 1'b1, 1'b0);
      do_read(8'h08, 0, 1'b0, 1'b0, 1'b0);
      do_read(8'h0C, 5, 1'b0, 1'b0, 1'b1);
      do_read(8'h10, 0, 1'b0, 1'b0, 1'b0);
      do_read(8'h40, 1, 1'b0, 1'b0, 1'b0);

      // ARVALID glitch between edges must not start a transaction
      @(negedge ACLK);
      axi.ARVALID = 1'b1;
      #2 axi.ARVALID = 1'b0;
      @(posedge ACLK); #1;
      check_eq("glitch_arready", 32'(axi.ARREADY), 32'd0);
      @(posedge ACLK); #1;
      check_eq("glitch_rvalid", 32'(axi.RVALID), 32'd0);

      // Reset while a response is pending
      pulse(1'b1, 1'b1);
      @(negedge ACLK);
      axi.ARADDR  = 32'h0000_0008;
      axi.ARVALID = 1'b1;
      @(posedge ACLK); #1;
      axi.ARVALID = 1'b0;
      @(posedge ACLK); #2;
      ARESETN = 1'b0;
      #1;
      check_eq("midrst_rvalid", 32'(axi.RVALID), 32'd0);
      check_eq("midrst_arready", 32'(axi.ARREADY), 32'd0);
      check_eq("midrst_rdata", axi.RDATA, 32'd0);
      m_done = 1'b0;
      m_ovf  = 1'b0;
      @(negedge ACLK);
      ARESETN = 1'b1;
      do_read(8'h08, 0, 1'b0, 1'b0, 1'b0);

      for (int k = 0; k < 40; k++) begin
         @(negedge ACLK);
         randomize_inputs();
         if ($urandom_range(0, 3) == 0)
            pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 4) == 0) begin
            r = $urandom();
            a = r[7:0];
         end else begin
            a = addr_list[$urandom_range(0, 5)];
         end
         do_read(a, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/adc16dv160_input_read.md
# adc16dv160_input_read

AXI4-Lite read-channel responder for the ADC16DV160 input core. Decodes single-beat reads on the AR/R channels and returns the control configuration (mirrored from the write-side registers), live capture status, sticky event flags and the captured-sample counter. It sits beside the AXI-Lite write logic inside the input core's register slave; the two share the address map from the common package.

## Interface
Parameters:
- ID_VALUE, 32'h1616_0100, constant returned by the ID register (used only when ADC16DV160_INPUT_ID_EN is defined)

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  reset, asynchronous, active-low
- ARADDR  in  32  read address; only [7:0] decoded
- ARVALID  in  1  address valid
- ARREADY  out  1  address accepted
- RDATA  out  32  read data
- RRESP  out  2  always 2'b00 (OKAY)
- RVALID  out  1  read data valid
- RREADY  in  1  master ready for data
- dsize  in  32  current DSIZE register value (write side)
- cr_test, cr_rt  in  1 each  current control bits (write side)
- busy  in  1  capture in progress (level)
- done_pulse  in  1  one-cycle pulse at capture completion
- ovf_pulse  in  1  one-cycle pulse on sample FIFO overflow
- sample_cnt  in  32  samples captured in current/last run

## Operation
- Register map (ARADDR[7:0]): CR 0x00 = {29'b0, cr_rt, cr_test, 1'b0}; bit0 (start) reads 0. DSIZE 0x04 = dsize. SR 0x08 = {29'b0, ovf_sticky, done_sticky, busy}. CNT 0x0C = sample_cnt. ID 0x10 = ID_VALUE (macro-dependent). Any other address: RDATA = 0, RRESP = OKAY.
- FSM states: IDLE, ADDR, DATA.
  - IDLE: ARREADY=0, RVALID=0; ARVALID=1 -> ADDR.
  - ADDR: ARREADY=1 for exactly one cycle; ARADDR decoded; selected value registered into RDATA at the clock edge leaving ADDR; -> DATA unconditionally.
  - DATA: RVALID=1; RDATA held stable; RREADY=1 -> IDLE.
- Sticky flags: done_sticky set by done_pulse, ovf_sticky set by ovf_pulse. Both cleared when an SR read completes (DATA state, RREADY=1, latched address = 0x08). Set pulse in the same cycle as the clear: set wins, flag stays 1.
- RDATA is a snapshot taken at the ADDR edge; changes on inputs during DATA do not alter RDATA.
- RRESP constant 2'b00.

## Timing
- Reset values: ARREADY=0, RVALID=0, RDATA=0, RRESP=0, done_sticky=0, ovf_sticky=0, state=IDLE.
- ARVALID sampled high in cycle N (IDLE) -> ARREADY=1 in N+1 -> RVALID=1 from N+2 -> one read minimum 3 cycles (RREADY held high).
- Back-to-back: after the DATA->IDLE edge, next ARVALID accepted no earlier than one IDLE cycle later (throughput 1 read / 3 cycles).
- RREADY stall: RVALID and RDATA held indefinitely; ARVALID ignored while in ADDR/DATA.
- ARVALID dropping in IDLE before acceptance: no transaction.
- Reset asserted mid-transaction: RVALID/ARREADY drop asynchronously, stickies clear, FSM to IDLE; no response completes.

## Configuration
- ADC16DV160_INPUT_ID_EN defined: address 0x10 returns ID_VALUE.
- Undefined: 0x10 treated as unmapped (RDATA=0, OKAY); ID_VALUE unused. No other behaviour differs.

## Structure
- Package adc16dv160_input_common: existing AXI_ADDR_CR, AXI_ADDR_DSIZE; add AXI_ADDR_SR (8'h08), AXI_ADDR_CNT (8'h0C), AXI_ADDR_ID (8'h10), SR bit-index constants.
- One sub-module: adc16dv160_input_sticky (set/clear flag, set-priority), instantiated twice.
- FSM, address latch, read mux in the top module.

## Test plan
- Reset, then read 0x04 with dsize=32'h0000_1000 and RREADY=1 -> ARREADY at N+1, RVALID at N+2, RDATA=0x1000, RRESP=0.
- cr_test=1, cr_rt=1, read 0x00 -> RDATA=32'h0000_0006.
- done_pulse once, read 0x08 with busy=0 -> RDATA=0x2; second read -> 0x0.
- ovf_pulse coincident with SR-read handshake -> next SR read returns bit2=1.
- RREADY low 5 cycles during CNT read while sample_cnt increments -> RVALID held, RDATA equals value sampled at ADDR cycle.
- Read 0x10: with macro -> 32'h1616_0100; without -> 0; read 0x40 -> 0, OKAY.
